// File: rtl/laser_packet_deframer.sv
// Receive-side packet deframer: hunts SYNC, buffers LEN payload bytes, verifies
// the XOR checksum and forwards good payloads to the FTDI write queue.
module laser_packet_deframer #(
   parameter int         MAX_LEN   = 16,
   parameter logic [7:0] SYNC_BYTE = 8'hA5,
   parameter int         TIMEOUT   = 1024
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       data_valid,
   input  logic       wrq_full,
   output logic       wrreq,
   output logic [7:0] data_wr,
   output logic       busy,
   output logic       pkt_done,
   output logic       csum_err,
   output logic       len_err,
   output logic       timeout_err,
   output logic       ovr_err,
   output logic [7:0] pkt_count
);

   // state     | meaning
   // S_IDLE    | hunting for SYNC_BYTE, other bytes ignored
   // S_LEN     | waiting for the length byte
   // S_PAYLOAD | capturing payload bytes into the buffer
   // S_CHECK   | waiting for the checksum byte
   // S_DRAIN   | writing buffered payload to the FTDI queue
   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_PAYLOAD,
      S_CHECK,
      S_DRAIN
   } state_t;

   localparam int          IW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int          TW    = $clog2(TIMEOUT);
   localparam logic [TW-1:0] TLOAD = TW'(TIMEOUT - 1);
   localparam logic [7:0]  MAXL  = 8'(MAX_LEN);

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [IW-1:0]   last_q, last_d;
   logic [7:0]      csum_q, csum_d;
   logic [TW-1:0]   tmr_q, tmr_d;
   logic [7:0]      cnt_q, cnt_d;
   logic            csum_err_q, csum_err_d;
   logic            len_err_q, len_err_d;
   logic            tmo_q, tmo_d;
   logic            ovr_q, ovr_d;
   logic            buf_we;
   logic            timed;
   logic [7:0]      pbuf_q [MAX_LEN];

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      last_d     = last_q;
      csum_d     = csum_q;
      cnt_d      = cnt_q;
      tmr_d      = TLOAD;
      csum_err_d = 1'b0;
      len_err_d  = 1'b0;
      tmo_d      = 1'b0;
      ovr_d      = 1'b0;
      buf_we     = 1'b0;
      timed      = 1'b0;
      wrreq      = 1'b0;
      pkt_done   = 1'b0;
      data_wr    = 8'h00;

      case (state_q)
         S_IDLE: begin
            if (data_valid && data_in == SYNC_BYTE) state_d = S_LEN;
         end
         S_LEN: begin
            timed = 1'b1;
            if (data_valid) begin
               if (data_in == 8'h00 || data_in > MAXL) begin
                  len_err_d = 1'b1;
                  state_d   = S_IDLE;
               end else begin
                  last_d  = IW'(data_in - 8'd1);
                  csum_d  = data_in;
                  idx_d   = '0;
                  state_d = S_PAYLOAD;
               end
            end
         end
         S_PAYLOAD: begin
            timed = 1'b1;
            if (data_valid) begin
               buf_we = 1'b1;
               csum_d = csum_q ^ data_in;
               idx_d  = idx_q + IW'(1);
               if (idx_q == last_q) state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            timed = 1'b1;
            if (data_valid) begin
               if (data_in == csum_q) begin
                  idx_d   = '0;
                  state_d = S_DRAIN;
               end else begin
                  csum_err_d = 1'b1;
                  state_d    = S_IDLE;
               end
            end
         end
         S_DRAIN: begin
            wrreq   = ~wrq_full;
            data_wr = pbuf_q[idx_q];
            ovr_d   = data_valid;
            if (!wrq_full) begin
               idx_d = idx_q + IW'(1);
               if (idx_q == last_q) begin
                  pkt_done = 1'b1;
                  cnt_d    = cnt_q + 8'd1;
                  state_d  = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // down-counting gap timer; an arriving byte wins over expiry
      if (timed && !data_valid) begin
         if (tmr_q == '0) begin
            tmo_d   = 1'b1;
            state_d = S_IDLE;
         end else begin
            tmr_d = tmr_q - TW'(1);
         end
      end
      if (state_d != state_q) tmr_d = TLOAD;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         last_q     <= '0;
         csum_q     <= 8'h00;
         tmr_q      <= TLOAD;
         cnt_q      <= 8'h00;
         csum_err_q <= 1'b0;
         len_err_q  <= 1'b0;
         tmo_q      <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         last_q     <= last_d;
         csum_q     <= csum_d;
         tmr_q      <= tmr_d;
         cnt_q      <= cnt_d;
         csum_err_q <= csum_err_d;
         len_err_q  <= len_err_d;
         tmo_q      <= tmo_d;
         ovr_q      <= ovr_d;
      end
   end

   always_ff @(posedge clock) begin
      if (buf_we) pbuf_q[idx_q] <= data_in;
   end

   assign busy        = (state_q != S_IDLE);
   assign csum_err    = csum_err_q;
   assign len_err     = len_err_q;
   assign timeout_err = tmo_q;
   assign ovr_err     = ovr_q;
   assign pkt_count   = cnt_q;

endmodule

// File: tb/tb_laser_packet_deframer.sv
// Randomized bench for laser_packet_deframer with a queue-based reference of
// expected FTDI writes and expected error-pulse counts.
module tb_laser_packet_deframer;

   localparam int         MAX_LEN = 16;
   localparam int         TIMEOUT = 1024;
   localparam logic [7:0] SYNC    = 8'hA5;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       data_valid = 1'b0;
   logic       wrq_full = 1'b0;
   logic       wrreq, busy, pkt_done, csum_err, len_err, timeout_err, ovr_err;
   logic [7:0] data_wr, pkt_count;

   laser_packet_deframer #(.MAX_LEN(MAX_LEN), .SYNC_BYTE(SYNC), .TIMEOUT(TIMEOUT)) dut (
      .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
      .wrq_full(wrq_full), .wrreq(wrreq), .data_wr(data_wr), .busy(busy),
      .pkt_done(pkt_done), .csum_err(csum_err), .len_err(len_err),
      .timeout_err(timeout_err), .ovr_err(ovr_err), .pkt_count(pkt_count)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } wexp_t;

   wexp_t      expq[$];
   wexp_t      wcur;
   logic [7:0] pl[$];
   logic [7:0] seq[$];
   logic [3:0] prev_e = 4'h0;
   logic [3:0] e_now;
   int n_checks = 0, n_fail = 0;
   int n_csum = 0, n_len = 0, n_tmo = 0, n_ovr = 0;
   int exp_csum = 0, exp_len = 0, exp_tmo = 0, exp_ovr = 0, exp_pkts = 0;
   int gap_max = 0;
   bit bp_rand = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // scoreboard: every write must match the next expected payload byte
   always @(negedge clock) begin
      if (reset) begin
         if (wrreq) begin
            if (expq.size() == 0) chk("unexpected_wrreq", 1, 0);
            else begin
               wcur = expq.pop_front();
               chk("wr_data", data_wr, wcur.data);
               chk("pkt_done", pkt_done, wcur.last);
            end
         end else begin
            chk("pkt_done_nowr", pkt_done, 0);
         end
         e_now = {csum_err, len_err, timeout_err, ovr_err};
         chk("pulse_width", e_now & prev_e, 0);
         prev_e = e_now;
         if (csum_err)    n_csum++;
         if (len_err)     n_len++;
         if (timeout_err) n_tmo++;
         if (ovr_err)     n_ovr++;
      end else begin
         prev_e = 4'h0;
      end
   end

   always @(posedge clock) begin
      #1;
      if (bp_rand) wrq_full = ($urandom_range(0, 3) == 0);
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      data_in    = b;
      data_valid = 1'b1;
      @(posedge clock);
      #1;
      data_valid = 1'b0;
      data_in    = 8'($urandom);
   endtask

   task automatic send_seq();
      foreach (seq[i]) send_byte(seq[i]);
   endtask

   task automatic fill_pl(input int len);
      pl.delete();
      for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
   endtask

   task automatic send_pl(input int len, input bit bad);
      logic [7:0] cs;
      cs = 8'(len);
      send_byte(SYNC);
      idle($urandom_range(0, gap_max));
      send_byte(8'(len));
      for (int i = 0; i < len; i++) begin
         idle($urandom_range(0, gap_max));
         send_byte(pl[i]);
         cs = cs ^ pl[i];
      end
      if (bad) exp_csum++;
      else begin
         for (int i = 0; i < len; i++) expq.push_back({pl[i], (i == len - 1)});
         exp_pkts++;
      end
      idle($urandom_range(0, gap_max));
      send_byte(bad ? (cs ^ 8'($urandom_range(1, 255))) : cs);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 400; i++) begin
         if (!busy && expq.size() == 0) break;
         @(posedge clock);
         #1;
      end
      chk("reach_idle", {31'd0, (!busy && expq.size() == 0)}, 1);
      idle(2);
   endtask

   task automatic check_counts();
      chk("pkt_count", pkt_count, exp_pkts[7:0]);
      chk("csum_err_cnt", n_csum, exp_csum);
      chk("len_err_cnt", n_len, exp_len);
      chk("timeout_err_cnt", n_tmo, exp_tmo);
      chk("ovr_err_cnt", n_ovr, exp_ovr);
   endtask

   task automatic chk_all_zero(input string tag);
      chk(tag, {busy, wrreq, pkt_done, csum_err, len_err, timeout_err, ovr_err}, 0);
      chk({tag, "_data_wr"}, data_wr, 0);
      chk({tag, "_pkt_count"}, pkt_count, 0);
   endtask

   initial begin
      logic [7:0] gexp [3];
      int kind, len;
      gexp[0] = 8'h11; gexp[1] = 8'h22; gexp[2] = 8'h33;

      idle(3);
      chk_all_zero("reset");
      reset = 1'b1;
      idle(2);

      // directed good packet: three back-to-back writes
      seq = {SYNC, 8'h03, 8'h11, 8'h22, 8'h33};
      send_seq();
      for (int i = 0; i < 3; i++) expq.push_back({gexp[i], (i == 2)});
      exp_pkts++;
      send_byte(8'h03);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk("good_wrreq", wrreq, 1);
         chk("good_data", data_wr, gexp[i]);
         chk("good_done", pkt_done, (i == 2));
      end
      wait_idle();
      check_counts();

      // bad checksum, then a normal packet
      seq = {SYNC, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04};
      exp_csum++;
      send_seq();
      wait_idle();
      check_counts();
      fill_pl(5);
      send_pl(5, 1'b0);
      wait_idle();
      check_counts();

      // length bounds
      seq = {SYNC, 8'h00};
      exp_len++;
      send_seq();
      wait_idle();
      seq = {SYNC, 8'h11};
      exp_len++;
      send_seq();
      wait_idle();
      fill_pl(MAX_LEN);
      send_pl(MAX_LEN, 1'b0);
      wait_idle();
      check_counts();

      // timeout expires on the TIMEOUT-th idle edge
      seq = {SYNC, 8'h02, 8'h11};
      send_seq();
      exp_tmo++;
      for (int k = 1; k <= TIMEOUT; k++) begin
         @(posedge clock);
         #1;
         chk("tmo_pulse", timeout_err, (k == TIMEOUT));
         chk("tmo_busy", busy, (k < TIMEOUT));
      end
      idle(2);
      check_counts();

      // byte arriving in the expiry cycle is accepted
      seq = {SYNC, 8'h02};
      send_seq();
      idle(TIMEOUT - 1);
      send_byte(8'h11);
      idle(TIMEOUT - 1);
      send_byte(8'h22);
      expq.push_back({8'h11, 1'b0});
      expq.push_back({8'h22, 1'b1});
      exp_pkts++;
      idle(TIMEOUT - 1);
      send_byte(8'h02 ^ 8'h11 ^ 8'h22);
      wait_idle();
      check_counts();

      // backpressure after the first write
      seq = {SYNC, 8'h03, 8'h11, 8'h22, 8'h33};
      send_seq();
      for (int i = 0; i < 3; i++) expq.push_back({gexp[i], (i == 2)});
      exp_pkts++;
      send_byte(8'h03);
      @(negedge clock);
      chk("bp_first", wrreq, 1);
      @(posedge clock);
      #1;
      wrq_full = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         chk("bp_hold", wrreq, 0);
         @(posedge clock);
         #1;
      end
      wrq_full = 1'b0;
      wait_idle();
      check_counts();

      // garbage before a packet, then overrun during drain
      seq = {8'h00, 8'hFF, 8'h5A};
      send_seq();
      fill_pl(4);
      send_pl(4, 1'b0);
      wait_idle();
      fill_pl(8);
      send_pl(8, 1'b0);
      send_byte(8'h77);
      exp_ovr++;
      wait_idle();
      check_counts();

      // randomized mix
      gap_max = 3;
      bp_rand = 1'b1;
      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(0, 3);
         len  = $urandom_range(1, MAX_LEN);
         case (kind)
            0: begin fill_pl(len); send_pl(len, 1'b0); end
            1: begin fill_pl(len); send_pl(len, 1'b1); end
            2: begin
               seq = {SYNC, (($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)))};
               exp_len++;
               send_seq();
            end
            default: begin
               seq.delete();
               for (int i = 0; i < 3; i++) seq.push_back(8'($urandom_range(0, 8'hA4)));
               send_seq();
            end
         endcase
         wait_idle();
      end
      check_counts();
      bp_rand = 1'b0;
      wrq_full = 1'b0;

      // reset mid-payload
      seq = {SYNC, 8'h05, 8'h11, 8'h22};
      send_seq();
      reset = 1'b0;
      idle(1);
      chk_all_zero("mid_reset");
      exp_pkts = 0;
      reset = 1'b1;
      idle(3);
      check_counts();

      // 256 good packets wrap the counter
      gap_max = 2;
      bp_rand = 1'b1;
      for (int n = 0; n < 256; n++) begin
         len = $urandom_range(1, MAX_LEN);
         fill_pl(len);
         send_pl(len, 1'b0);
         wait_idle();
         if (n == 254) chk("pre_wrap", pkt_count, 8'hFF);
      end
      bp_rand = 1'b0;
      chk("wrap", pkt_count, 0);
      check_counts();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/laser_packet_deframer.md
Name: laser_packet_deframer

Overview:
Packet-layer receiver sitting between the laser byte receiver (data_in/data_valid) and the FTDI interface write queue (wrreq/data_wr/wrq_full). It is the receive-side counterpart of the laser packet framing used on the transmit path.
- Hunts for a sync byte, captures length and payload into an internal buffer, and verifies an XOR checksum.
- Forwards the payload to the FTDI write queue only if the packet is valid; corrupt, oversized or stalled packets are discarded whole.

Parameters:
MAX_LEN, 16, maximum payload bytes per packet (buffer depth, 1..255)
SYNC_BYTE, 8'hA5, start-of-packet marker
TIMEOUT, 1024, consecutive idle cycles mid-packet before abort (>=2)

Ports:
clock  input  1  system clock (50 MHz domain, same as LaserReceiver)
reset  input  1  synchronous, active-low reset
data_in  input  8  byte from laser receiver
data_valid  input  1  1-cycle strobe: data_in valid this cycle
wrq_full  input  1  FTDI write queue full
wrreq  output  1  write strobe into FTDI write queue
data_wr  output  8  byte presented with wrreq
busy  output  1  high in any state other than IDLE
pkt_done  output  1  1-cycle pulse: last payload byte written
csum_err  output  1  1-cycle pulse: checksum mismatch, packet dropped
len_err  output  1  1-cycle pulse: length 0 or >MAX_LEN, packet dropped
timeout_err  output  1  1-cycle pulse: inter-byte gap exceeded, packet dropped
ovr_err  output  1  1-cycle pulse: byte arrived during DRAIN and was dropped
pkt_count  output  8  count of good packets delivered, wraps 255->0

Behaviour:
- Reset (reset==0 at posedge): state IDLE; all pulse outputs, busy, wrreq and pkt_count are 0; data_wr is 0. Counters and checksum are cleared. Reset mid-packet discards the buffer with no error pulse.
- Packet format: SYNC_BYTE, LEN, LEN payload bytes, CSUM. CSUM = LEN XOR all payload bytes.
- IDLE:
  - A data_valid byte equal to SYNC_BYTE -> LEN.
  - Any other byte is ignored silently.
- LEN: on data_valid:
  - data_in==0 or data_in>MAX_LEN -> len_err pulse next cycle, go to IDLE.
  - Otherwise latch len=data_in, csum=data_in, wr_idx=0, go to PAYLOAD.
- PAYLOAD: each data_valid does buf[wr_idx]<=data_in, csum<=csum^data_in, wr_idx++. When the byte with wr_idx==len-1 is accepted -> CHECK.
- CHECK: on data_valid:
  - data_in==csum -> rd_idx=0, go to DRAIN.
  - Otherwise csum_err pulse, go to IDLE.
  - A SYNC_BYTE value here is treated as a checksum byte, not a resync.
- DRAIN:
  - wrreq = (state==DRAIN) & ~wrq_full, combinational; data_wr = buf[rd_idx], combinational.
  - Each cycle with wrreq=1: rd_idx++.
  - On the cycle the byte with rd_idx==len-1 is written: pkt_done pulses in the same cycle, pkt_count increments, next state is IDLE.
  - While wrq_full is high, rd_idx holds and no bytes are lost.
- Timeout:
  - The idle counter runs in LEN, PAYLOAD and CHECK. It is cleared on each data_valid and on every state entry.
  - On the TIMEOUT-th consecutive cycle without data_valid: timeout_err pulse, go to IDLE.
  - The counter does not run in IDLE or DRAIN.
- Overrun: a data_valid during DRAIN drops the byte and pulses ovr_err. DRAIN continues unaffected.
- Error pulses are registered: high exactly one cycle, the cycle after the offending byte or timeout.
- Simultaneous events: in the timeout-expiry cycle, a data_valid takes priority (byte accepted, counter cleared).
- Latency: first wrreq can occur 1 cycle after the CSUM byte's data_valid cycle. Drain then proceeds at 1 byte/cycle absent backpressure.
- busy is high from the cycle after SYNC acceptance until the cycle IDLE is re-entered.

Test Plan:
- Good packet: A5 03 11 22 33 03 -> wrreq on 3 consecutive cycles with data_wr 11,22,33; pkt_done coincident with 33; pkt_count=1; no error pulses.
- Bad checksum: A5 03 11 22 33 04 -> csum_err one cycle; wrreq never asserts; pkt_count unchanged; a following good packet is delivered normally.
- Length bounds: A5 00 -> len_err; A5 11 (17>16) -> len_err; A5 10 with 16 bytes and the correct csum -> all 16 delivered.
- Timeout and backpressure:
  - A5 02 11, then 1024 idle cycles -> timeout_err on exactly the 1024th idle cycle; busy drops; no wrreq.
  - Good 3-byte packet with wrq_full held high for 5 cycles after the first write -> bytes 11,22,33 each written exactly once, in order.
- Garbage and overrun:
  - Bytes 00 FF 5A, then a good packet -> garbage ignored, packet delivered.
  - data_valid during DRAIN -> ovr_err pulse; drain completes intact.
- Reset and wrap:
  - Assert reset mid-PAYLOAD -> IDLE, all outputs 0, no error pulse.
  - 256 good packets -> pkt_count wraps to 0.
